bullet_pool: RTL and testbench
==============================

# bullet_pool

Parametrised multi-shot projectile engine for one tank. It holds `NUM_SLOTS` independent bullets, each with its own flight/explosion state machine. New shots are allocated to the lowest free slot, subject to a frame-based cooldown. The block sits between the tank movement logic (muzzle position, facing) and the colour mapper (per-pixel `is_bullet`/`is_boom`). It also exposes per-slot positions so collision logic can return per-slot hit flags.

## Interface
- `NUM_SLOTS`, 4: number of concurrent bullets (1–8).
- `STEP`, 6: pixels moved per frame tick.
- `SIZE`, 3: bullet draw radius.
- `BOOM_SIZE`, 19: explosion box side.
- `X_MIN`/`X_MAX`/`Y_MIN`/`Y_MAX`, 2/478/20/478: playfield bounds.
- `COOLDOWN_FRAMES`, 8: minimum frame ticks between accepted shots.
- `LIFE_FRAMES`, 96: maximum flight duration in frame ticks.
- `BOOM_FRAMES`, 15: explosion duration in frame ticks.
- `Clk`  in  1  system clock; one clock for the whole block.
- `Reset`  in  1  asynchronous, active-high reset.
- `frame_clk`  in  1  vertical-sync-rate strobe; asynchronous to game logic, synchronised internally.
- `enable`  in  1  game in play mode; when low, no launches and both draw outputs are 0.
- `fire`  in  1  shoot key level; only its rising edge launches.
- `dir`  in  2  facing: 0 right, 1 up, 2 left, 3 down.
- `spawn_x`, `spawn_y`  in  10 each  muzzle point for the current `dir`.
- `stop_bullet`  in  `NUM_SLOTS`  per-slot wall/tank hit flag.
- `DrawX`, `DrawY`  in  10 each  current pixel.
- `bullet_x`, `bullet_y`  out  `10*NUM_SLOTS` each  packed slot positions; slot i is at bits [10i+9:10i].
- `active_mask`  out  `NUM_SLOTS`  slot in FLY.
- `boom_mask`  out  `NUM_SLOTS`  slot in BOOM.
- `fire_ack`  out  1  one-cycle pulse: shot accepted.
- `fire_drop`  out  1  one-cycle pulse: shot rejected because the pool is full (cooldown expired).
- `is_bullet`, `is_boom`  out  1 each  pixel is covered by a bullet or an explosion.

## Operation
- Frame tick:
  - `frame_clk` passes through a 2-flop synchroniser, then rising-edge detection.
  - The result is a one-`Clk` `tick` pulse.
  - All movement and all frame counters advance only on `tick`.
- Per-slot FSM:
  - IDLE → FLY on allocation.
  - FLY → BOOM on hit or boundary.
  - FLY → IDLE when the life counter reaches `LIFE_FRAMES`.
  - BOOM → IDLE when the boom counter reaches `BOOM_FRAMES`.
- Launch:
  - `fire_edge = fire & ~fire_q`.
  - The launch is accepted when `fire_edge`, `enable`, cooldown is 0 and at least one slot is IDLE.
  - The lowest-index IDLE slot loads `spawn_x`/`spawn_y` and the motion for `dir`, and resets its life counter.
  - Cooldown loads `COOLDOWN_FRAMES`.
- Motion: 10-bit two's complement; `STEP` or `-STEP` on one axis, 0 on the other.
- FLY update on `tick`:
  - If `stop_bullet[i]` → BOOM at the current position.
  - Else if current position + motion is outside [`X_MIN`, `X_MAX-SIZE`] × [`Y_MIN`, `Y_MAX-SIZE`] → BOOM at the current position, with no move.
  - Else move by the motion and increment life.
- Boundary comparisons use 11-bit signed arithmetic, so a negative result never wraps.
- `is_bullet`:
  - Set when any FLY slot has dx²+dy² ≤ SIZE², with dx = DrawX−x and dy = DrawY−y as signed 11-bit values.
  - Computed combinationally.
- `is_boom`: set when any BOOM slot has −BOOM_SIZE/2 ≤ dx < BOOM_SIZE/2, and the same condition on dy.
- Cooldown decrements on `tick` while nonzero.

## Timing
- Reset values:
  - All slots IDLE.
  - All positions 0; all counters 0.
  - `fire_q` 0; cooldown 0.
  - All outputs 0.
  - Reset mid-flight or mid-boom clears the slot immediately.
- Launch latency:
  - The `fire` rise sampled at edge N produces `fire_edge` in cycle N.
  - At edge N+1 the slot becomes FLY and `fire_ack` goes high for exactly that one cycle.
  - `fire_drop` follows the same timing.
- A slot launched in the same cycle as `tick` does not move on that tick.
- Slot release and `fire_edge` in the same cycle: the released slot is not eligible until the next cycle.
- A held `fire` never fires again; a `fire_edge` during cooldown is ignored silently (no `fire_drop`).
- `stop_bullet` is sampled only on `tick`.

## Configuration
- `BULLET_POOL_BOOM_EN` defined:
  - The BOOM state exists.
  - `boom_mask` and `is_boom` behave as above.
- Undefined:
  - Hits and boundaries go FLY → IDLE directly.
  - `boom_mask` and `is_boom` are constant 0.
  - No boom counters are built.

## Structure
- Package `bullet_pkg`:
  - `dir_t` enum (RIGHT, UP, LEFT, DOWN).
  - `slot_state_t` enum (IDLE, FLY, BOOM).
  - `motion_for(dir_t)` function returning signed X/Y steps.
- Sub-module `bullet_slot`:
  - One instance per slot via generate.
  - Contains the FSM, position, life/boom counters and the pixel hit tests.
- Top level contains the synchroniser, edge detect, allocator (priority encoder), cooldown and OR-reduction.

## Test plan
- Reset, then `fire` pulse with dir=0 at spawn (100,200) → `fire_ack` next cycle; slot0 x=106 after 1 tick, 112 after 2.
- Five fire pulses spaced 10 ticks apart, NUM_SLOTS=4, no releases → slots 0–3 fill; fifth gives `fire_drop`.
- Fire pulses 3 ticks apart with COOLDOWN_FRAMES=8 → second pulse gives neither ack nor drop.
- dir=2 at spawn x=8 → one tick to x=2 (inside), next tick enters BOOM at x=2; with BOOM_EN, IDLE after 15 ticks.
- `stop_bullet[1]` asserted on a tick for flying slot1 → slot1 BOOM, slot0 unaffected; `is_boom`=1 at DrawX=x−9, 0 at x+9.
- Assert Reset mid-flight between two ticks → `active_mask`=0 and positions 0 immediately, with no Clk edge needed.

Source files
------------

// File: rtl/bullet_pkg.sv
// Shared types for the bullet pool: facing, per-slot state and the motion vector.
package bullet_pkg;

  typedef enum logic [1:0] {RIGHT = 2'd0, UP = 2'd1, LEFT = 2'd2, DOWN = 2'd3} dir_t;
  typedef enum logic [1:0] {IDLE = 2'd0, FLY = 2'd1, BOOM = 2'd2} slot_state_t;

  typedef struct packed {
    logic signed [9:0] dx;
    logic signed [9:0] dy;
  } motion_t;

  // Screen coordinates: y grows downward, so UP is a negative y step.
  function automatic motion_t motion_for(dir_t d, int step);
    motion_t m;
    m.dx = '0;
    m.dy = '0;
    case (d)
      RIGHT: m.dx = 10'(step);
      UP:    m.dy = -10'(step);
      LEFT:  m.dx = -10'(step);
      DOWN:  m.dy = 10'(step);
      default: ;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/bullet_slot.sv
// One projectile: FSM, position, life/boom counters and pixel coverage tests.
// Explosion state is built only when BULLET_POOL_BOOM_EN is defined.
module bullet_slot import bullet_pkg::*; #(
  parameter int SIZE        = 3,
  parameter int BOOM_SIZE   = 19,
  parameter int X_MIN       = 2,
  parameter int X_MAX       = 478,
  parameter int Y_MIN       = 20,
  parameter int Y_MAX       = 478,
  parameter int LIFE_FRAMES = 96,
  parameter int BOOM_FRAMES = 15
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       tick,
  input  logic       load,
  input  logic       stop,
  input  logic [9:0] spawn_x,
  input  logic [9:0] spawn_y,
  input  motion_t    mv,
  input  logic [9:0] DrawX,
  input  logic [9:0] DrawY,
  output logic [9:0] x,
  output logic [9:0] y,
  output logic       fly,
  output logic       boom,
  output logic       is_bullet,
  output logic       is_boom
);

  localparam int LW = $clog2(LIFE_FRAMES + 1);
  localparam logic [LW-1:0] LIFE_LAST = LW'(LIFE_FRAMES - 1);
  localparam logic signed [10:0] XLO = 11'(X_MIN);
  localparam logic signed [10:0] XHI = 11'(X_MAX - SIZE);
  localparam logic signed [10:0] YLO = 11'(Y_MIN);
  localparam logic signed [10:0] YHI = 11'(Y_MAX - SIZE);
  localparam logic [22:0] R2 = 23'(SIZE * SIZE);
`ifdef BULLET_POOL_BOOM_EN
  localparam slot_state_t HIT_ST = BOOM;
`else
  localparam slot_state_t HIT_ST = IDLE;
`endif

  slot_state_t state, nstate;
  motion_t mv_q;
  logic [LW-1:0] life;
  logic signed [10:0] nx, ny, dx, dy;
  logic signed [21:0] dx2, dy2;
  logic [22:0] d2;
  logic oob, advance;

  // Widen to 11-bit signed so a step past 0 goes negative instead of wrapping.
  assign nx  = $signed({1'b0, x}) + $signed({mv_q.dx[9], mv_q.dx});
  assign ny  = $signed({1'b0, y}) + $signed({mv_q.dy[9], mv_q.dy});
  assign oob = (nx < XLO) || (nx > XHI) || (ny < YLO) || (ny > YHI);
  assign advance = (state == FLY) && tick && !stop && !oob;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) state <= IDLE;
    else       state <= nstate;
  end

`ifdef BULLET_POOL_BOOM_EN
  localparam int BW = $clog2(BOOM_FRAMES + 1);
  localparam logic [BW-1:0] BOOM_LAST = BW'(BOOM_FRAMES - 1);
  logic [BW-1:0] boom_cnt;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset)                             boom_cnt <= '0;
    else if (state == FLY && nstate == BOOM) boom_cnt <= '0;
    else if (state == BOOM && tick)        boom_cnt <= boom_cnt + 1'b1;
  end
`endif

  always_comb begin
    nstate = state;
    case (state)
      IDLE: if (load) nstate = FLY;
      FLY: if (tick) begin
        if (stop || oob)             nstate = HIT_ST;
        else if (life == LIFE_LAST)  nstate = IDLE;
      end
`ifdef BULLET_POOL_BOOM_EN
      BOOM: if (tick && boom_cnt == BOOM_LAST) nstate = IDLE;
`endif
      default: nstate = IDLE;
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      x    <= '0;
      y    <= '0;
      mv_q <= '0;
      life <= '0;
    end else if (load && state == IDLE) begin
      x    <= spawn_x;
      y    <= spawn_y;
      mv_q <= mv;
      life <= '0;
    end else if (advance) begin
      x    <= nx[9:0];
      y    <= ny[9:0];
      life <= life + 1'b1;
    end
  end

  assign dx  = $signed({1'b0, DrawX}) - $signed({1'b0, x});
  assign dy  = $signed({1'b0, DrawY}) - $signed({1'b0, y});
  assign dx2 = dx * dx;
  assign dy2 = dy * dy;
  assign d2  = {1'b0, dx2} + {1'b0, dy2};

  always_comb begin
    fly       = (state == FLY);
    is_bullet = fly && (d2 <= R2);
`ifdef BULLET_POOL_BOOM_EN
    boom    = (state == BOOM);
    is_boom = boom && (dx >= -11'(BOOM_SIZE / 2)) && (dx < 11'(BOOM_SIZE / 2))
                   && (dy >= -11'(BOOM_SIZE / 2)) && (dy < 11'(BOOM_SIZE / 2));
`else
    boom    = 1'b0;
    is_boom = 1'b0;
`endif
  end

endmodule

// File: rtl/bullet_pool.sv
// Multi-shot projectile engine: frame tick sync, lowest-free-slot allocator, cooldown.
// Define BULLET_POOL_BOOM_EN to build the explosion state in every slot.
module bullet_pool import bullet_pkg::*; #(
  parameter int NUM_SLOTS       = 4,
  parameter int STEP            = 6,
  parameter int SIZE            = 3,
  parameter int BOOM_SIZE       = 19,
  parameter int X_MIN           = 2,
  parameter int X_MAX           = 478,
  parameter int Y_MIN           = 20,
  parameter int Y_MAX           = 478,
  parameter int COOLDOWN_FRAMES = 8,
  parameter int LIFE_FRAMES     = 96,
  parameter int BOOM_FRAMES     = 15
) (
  input  logic                          Clk,
  input  logic                          Reset,
  input  logic                          frame_clk,
  input  logic                          enable,
  input  logic                          fire,
  input  logic [1:0]                    dir,
  input  logic [9:0]                    spawn_x,
  input  logic [9:0]                    spawn_y,
  input  logic [NUM_SLOTS-1:0]          stop_bullet,
  input  logic [9:0]                    DrawX,
  input  logic [9:0]                    DrawY,
  output logic [NUM_SLOTS-1:0][9:0]     bullet_x,
  output logic [NUM_SLOTS-1:0][9:0]     bullet_y,
  output logic [NUM_SLOTS-1:0]          active_mask,
  output logic [NUM_SLOTS-1:0]          boom_mask,
  output logic                          fire_ack,
  output logic                          fire_drop,
  output logic                          is_bullet,
  output logic                          is_boom
);

  localparam int CW = $clog2(COOLDOWN_FRAMES + 1);

  logic [2:0] fs_pipe;
  logic tick, fire_q, fire_edge, ready, launch, drop, found;
  logic [CW-1:0] cd;
  logic [NUM_SLOTS-1:0] idle, load_oh, hit_b, hit_x;
  motion_t mv;

  // Two sync flops then one history flop for rising-edge detect.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) fs_pipe <= '0;
    else       fs_pipe <= {fs_pipe[1:0], frame_clk};
  end
  assign tick = fs_pipe[1] & ~fs_pipe[2];

  assign fire_edge = fire & ~fire_q;
  assign idle      = ~(active_mask | boom_mask);
  assign ready     = fire_edge & enable & (cd == '0);
  assign launch    = ready & (|idle);
  assign drop      = ready & ~(|idle);
  assign mv        = motion_for(dir_t'(dir), STEP);

  always_comb begin
    load_oh = '0;
    found   = 1'b0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      if (idle[i] && !found) begin
        load_oh[i] = launch;
        found      = 1'b1;
      end
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      fire_q    <= 1'b0;
      cd        <= '0;
      fire_ack  <= 1'b0;
      fire_drop <= 1'b0;
    end else begin
      fire_q    <= fire;
      fire_ack  <= launch;
      fire_drop <= drop;
      if (launch)                cd <= CW'(COOLDOWN_FRAMES);
      else if (tick && cd != '0) cd <= cd - 1'b1;
    end
  end

  for (genvar i = 0; i < NUM_SLOTS; i++) begin : g_slot
    bullet_slot #(
      .SIZE(SIZE), .BOOM_SIZE(BOOM_SIZE),
      .X_MIN(X_MIN), .X_MAX(X_MAX), .Y_MIN(Y_MIN), .Y_MAX(Y_MAX),
      .LIFE_FRAMES(LIFE_FRAMES), .BOOM_FRAMES(BOOM_FRAMES)
    ) u_slot (
      .Clk(Clk), .Reset(Reset), .tick(tick), .load(load_oh[i]), .stop(stop_bullet[i]),
      .spawn_x(spawn_x), .spawn_y(spawn_y), .mv(mv),
      .DrawX(DrawX), .DrawY(DrawY),
      .x(bullet_x[i]), .y(bullet_y[i]),
      .fly(active_mask[i]), .boom(boom_mask[i]),
      .is_bullet(hit_b[i]), .is_boom(hit_x[i])
    );
  end

  assign is_bullet = enable & (|hit_b);
  assign is_boom   = enable & (|hit_x);

endmodule

// File: tb/tb_bullet_pool.sv
// Directed bench for bullet_pool: launch, motion, cooldown, pool-full, hit, boundary, reset.
module tb_bullet_pool;

`ifdef BULLET_POOL_BOOM_EN
  localparam int BOOM_ON = 1;
`else
  localparam int BOOM_ON = 0;
`endif

  logic Clk = 0, Reset = 1, frame_clk = 0, enable = 0, fire = 0;
  logic [1:0] dir = 0;
  logic [9:0] spawn_x = 0, spawn_y = 0, DrawX = 0, DrawY = 0;
  logic [3:0] stop_bullet = 0;
  logic [3:0][9:0] bullet_x, bullet_y;
  logic [3:0] active_mask, boom_mask;
  logic fire_ack, fire_drop, is_bullet, is_boom;
  int n_chk = 0, n_err = 0;
  int acks, drops;

  bullet_pool dut (
    .Clk(Clk), .Reset(Reset), .frame_clk(frame_clk), .enable(enable), .fire(fire),
    .dir(dir), .spawn_x(spawn_x), .spawn_y(spawn_y), .stop_bullet(stop_bullet),
    .DrawX(DrawX), .DrawY(DrawY), .bullet_x(bullet_x), .bullet_y(bullet_y),
    .active_mask(active_mask), .boom_mask(boom_mask), .fire_ack(fire_ack),
    .fire_drop(fire_drop), .is_bullet(is_bullet), .is_boom(is_boom)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic do_tick();
    @(negedge Clk) frame_clk = 1;
    repeat (4) @(negedge Clk);
    frame_clk = 0;
    repeat (3) @(negedge Clk);
  endtask

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) do_tick();
  endtask

  task automatic fire_pulse(input logic [1:0] d, input int sx, input int sy);
    @(negedge Clk);
    dir = d; spawn_x = 10'(sx); spawn_y = 10'(sy); fire = 1;
    acks = 0; drops = 0;
    repeat (3) begin
      @(posedge Clk); #1;
      acks += int'(fire_ack);
      drops += int'(fire_drop);
    end
    fire = 0;
  endtask

  initial begin
    repeat (3) @(posedge Clk);
    #1;
    chk("rst_active", active_mask, 0);
    chk("rst_boom", boom_mask, 0);
    chk("rst_x0", bullet_x[0], 0);
    chk("rst_ack", fire_ack, 0);
    chk("rst_isb", is_bullet, 0);
    @(negedge Clk) Reset = 0;
    enable = 1;

    // First launch: exact latency and one-cycle ack.
    @(negedge Clk);
    dir = 0; spawn_x = 100; spawn_y = 200; fire = 1;
    @(posedge Clk); #1;
    chk("l0_ack", fire_ack, 1);
    chk("l0_active", active_mask, 4'b0001);
    chk("l0_x", bullet_x[0], 100);
    @(posedge Clk); #1;
    chk("l0_ack_low", fire_ack, 0);
    fire = 0;
    do_tick();
    chk("l0_x_t1", bullet_x[0], 106);
    do_tick();
    chk("l0_x_t2", bullet_x[0], 112);
    chk("l0_y_t2", bullet_y[0], 200);

    DrawX = 112; DrawY = 200; #1;
    chk("isb_center", is_bullet, 1);
    DrawX = 115; #1;
    chk("isb_edge", is_bullet, 1);
    DrawX = 116; #1;
    chk("isb_out", is_bullet, 0);
    DrawX = 114; DrawY = 202; #1;
    chk("isb_diag", is_bullet, 1);
    DrawX = 112; DrawY = 200; enable = 0; #1;
    chk("isb_disabled", is_bullet, 0);
    enable = 1;

    // Cooldown still running (6 ticks left): silent ignore.
    fire_pulse(2'd3, 50, 50);
    chk("cd_ack", acks, 0);
    chk("cd_drop", drops, 0);
    chk("cd_active", active_mask, 4'b0001);
    ticks(6);
    chk("l0_x_t8", bullet_x[0], 148);

    // Fill the pool, fifth shot dropped.
    fire_pulse(2'd1, 300, 400);
    chk("s1_ack", acks, 1);
    chk("s1_active", active_mask, 4'b0011);
    ticks(10);
    chk("s1_y", bullet_y[1], 340);
    fire_pulse(2'd3, 50, 30);
    chk("s2_ack", acks, 1);
    ticks(10);
    fire_pulse(2'd0, 20, 100);
    chk("s3_ack", acks, 1);
    chk("s3_active", active_mask, 4'b1111);
    ticks(10);
    fire_pulse(2'd2, 200, 200);
    chk("full_ack", acks, 0);
    chk("full_drop", drops, 1);
    chk("s1_y_t30", bullet_y[1], 220);

    // Hit on slot1 only.
    @(negedge Clk) stop_bullet = 4'b0010;
    do_tick();
    stop_bullet = 0;
    chk("hit_active", active_mask, 4'b1101);
    chk("hit_boom", boom_mask, BOOM_ON ? 4'b0010 : 4'b0000);
    chk("hit_s1_y", bullet_y[1], 220);
    chk("hit_s0_x", bullet_x[0], 334);
    DrawX = 291; DrawY = 220; #1;
    chk("boom_lo", is_boom, BOOM_ON);
    DrawX = 309; #1;
    chk("boom_hi", is_boom, 0);
    ticks(14);
    chk("hit_boom14", int'(boom_mask[1]), BOOM_ON);
    do_tick();
    chk("hit_boom15", int'(boom_mask[1]), 0);
    chk("s0_x_t54", bullet_x[0], 424);

    // Left-wall boundary on reused slot1.
    fire_pulse(2'd2, 8, 250);
    chk("b_ack", acks, 1);
    chk("b_active", active_mask, 4'b1111);
    do_tick();
    chk("b_x_t1", bullet_x[1], 2);
    chk("b_fly_t1", int'(active_mask[1]), 1);
    do_tick();
    chk("b_fly_t2", int'(active_mask[1]), 0);
    chk("b_boom_t2", int'(boom_mask[1]), BOOM_ON);
    chk("b_x_t2", bullet_x[1], 2);
    ticks(14);
    chk("b_boom_14", int'(boom_mask[1]), BOOM_ON);
    do_tick();
    chk("b_boom_15", int'(boom_mask[1]), 0);

    // Asynchronous reset between clock edges.
    chk("pre_rst_s2", int'(active_mask[2]), 1);
    @(posedge Clk); #2;
    Reset = 1; #1;
    chk("arst_active", active_mask, 0);
    chk("arst_boom", boom_mask, 0);
    chk("arst_x", bullet_x, 0);
    chk("arst_y", bullet_y, 0);
    @(negedge Clk) Reset = 0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end

endmodule
